// File: rtl/seq_div4.sv
// Multi-cycle restoring divider, one quotient bit per clock, with a done pulse.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_div4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

`ifdef DIV_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;
    logic ovf_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    assign dvd_mag = mag(dividend);
    assign dvs_mag = mag(divisor);
`else
    assign dvd_mag  = dividend;
    assign dvs_mag  = divisor;
    assign overflow = 1'b0;
`endif

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One restoring step: shift in next dividend bit, trial-subtract via invert-plus-one
    always_comb begin
        r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        t    = r_sh + ~{1'b0, dvs_q} + (WIDTH+1)'(1);
        if (!t[WIDTH]) begin
            r_next = t;
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_sh;
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            overflow    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                r_q         <= '0;
                q_q         <= dvd_mag;
                dvs_q       <= dvs_mag;
                cnt_q       <= '0;
                div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                overflow    <= 1'b0;
                neg_q_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                neg_r_q     <= dividend[WIDTH-1];
                ovf_q       <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
                if (divisor == '0) begin
                    // Zero divisor short-circuits straight to DONE
                    state       <= DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    state <= CALC;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    CALC: begin
                        r_q   <= r_next;
                        q_q   <= q_next;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef DIV_SIGNED_EN
                            quotient  <= neg_q_q ? (~q_next + WIDTH'(1)) : q_next;
                            remainder <= neg_r_q ? (~r_next[WIDTH-1:0] + WIDTH'(1))
                                                 : r_next[WIDTH-1:0];
                            overflow  <= ovf_q;
`else
                            quotient  <= q_next;
                            remainder <= r_next[WIDTH-1:0];
`endif
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_div4.sv
// Self-checking bench for seq_div4: directed cases plus randomized traffic vs. an arithmetic model.
module tb_seq_div4;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: busy cycles remaining, and results visible after the latest edge
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    logic         m_dbz, m_ovf, p_ovf;

    seq_div4 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
        p_q = '0; p_r = '0; p_ovf = 1'b0;
    endtask

    task automatic model_result(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_SIGNED_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sa == -(2 ** (W - 1)) && sb == -1) begin
            p_q = a; p_r = '0; p_ovf = 1'b1;
        end else begin
            p_q = W'(sa / sb); p_r = W'(sa % sb); p_ovf = 1'b0;
        end
`else
        p_q = W'(int'(a) / int'(b));
        p_r = W'(int'(a) % int'(b));
        p_ovf = 1'b0;
`endif
    endtask

    // Advance the model by one rising edge with the given inputs
    task automatic model_step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic nd;
        nd = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                nd = 1'b1; m_q = p_q; m_r = p_r; m_ovf = p_ovf;
            end
        end else if (s) begin
            m_dbz = 1'b0; m_ovf = 1'b0;
            if (b == '0) begin
                nd = 1'b1; m_q = '1; m_r = a; m_dbz = 1'b1;
            end else begin
                m_left = W;
                model_result(a, b);
            end
        end
        m_done = nd;
    endtask

    task automatic compare_all();
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("quotient", 32'(quotient), 32'(m_q));
        check("remainder", 32'(remainder), 32'(m_r));
        check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called at a falling edge: drive, wait one rising edge, then compare at the next falling edge
    task automatic tick(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic rn);
        start = s; dividend = a; divisor = b;
        if (!rn) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            rst_n = 1'b1;
        end
        @(posedge clk);
        if (rn) model_step(s, a, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_q"}, 32'(quotient), 32'd0);
        check({tag, "_r"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        model_reset();
        #1 check_all_zero("reset");
        @(negedge clk);
        tick(1'b0, 4'd0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 4'd0, 1'b1);

        // 13/3: busy for four cycles, then done with q=4 r=1
        tick(1'b1, 4'd13, 4'd3, 1'b1);
        check("t1_busy_first", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t1_busy_last", 32'(busy), 32'd1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_q", 32'(quotient), 32'd4);
        check("t1_r", 32'(remainder), 32'd1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t1_done_pulse", 32'(done), 32'd0);

        // 7/0: immediate done, flagged
        tick(1'b1, 4'd7, 4'd0, 1'b1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_q", 32'(quotient), 32'hF);
        check("t2_r", 32'(remainder), 32'd7);
        check("t2_dbz", 32'(div_by_zero), 32'd1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);

        // 15/15 with 9/2 requested while busy: the second request is ignored
        tick(1'b1, 4'd15, 4'd15, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'd9, 4'd2, 1'b1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t3_done", 32'(done), 32'd1);
        check("t3_q", 32'(quotient), 32'd1);
        check("t3_r", 32'(remainder), 32'd0);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t3_no_second", 32'(busy), 32'd0);

        // 12/5 interrupted by reset, then rerun
        tick(1'b1, 4'd12, 4'd5, 1'b1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("t4_async");
        @(negedge clk);
        tick(1'b0, 4'd0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        tick(1'b1, 4'd12, 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_q", 32'(quotient), 32'd2);
        check("t4_r", 32'(remainder), 32'd2);
        tick(1'b0, 4'd0, 4'd0, 1'b1);

`ifdef DIV_SIGNED_EN
        tick(1'b1, 4'b1001, 4'b0010, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t5_q", 32'(quotient), 32'hD);
        check("t5_r", 32'(remainder), 32'hF);
        tick(1'b1, 4'b1000, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
        check("t6_q", 32'(quotient), 32'h8);
        check("t6_r", 32'(remainder), 32'h0);
        check("t6_ovf", 32'(overflow), 32'd1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
`endif

        // Randomized traffic: sporadic starts, zero divisors, occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic         s;
            logic         rn;
            logic [W-1:0] a, b;
            s  = ($urandom_range(0, 2) != 0);
            rn = ($urandom_range(0, 199) != 0);
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            tick(s, a, b, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
